kernel_run_ctrl: RTL and testbench

KERNEL_RUN_CTRL -- requirements
Module: kernel_run_ctrl

---
 rtl/kernel_run_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_kernel_run_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : kernel_run_ctrl
// Brief   : Drives repeated ap_ctrl_hs kernel runs across rotating datasets,
//           with a per-run watchdog and a rolling checksum of kernel output.
// Revision: 1.0
// ============================================================================
module kernel_run_ctrl #(
  parameter int  DATASET_NUM    = 8,
  parameter int  TIMEOUT_CYCLES = 1 << 24,
  localparam int DS_W           = (DATASET_NUM > 1) ? $clog2(DATASET_NUM) : 1
) (
  input  logic            ap_clk,
  input  logic            ap_rst,
  input  logic            enable,
  input  logic [15:0]     num_runs,
  input  logic [15:0]     gap_cycles,
  output logic            k_ap_start,
  input  logic            k_ap_ready,
  input  logic            k_ap_done,
  input  logic            out_write,
  input  logic [31:0]     out_din,
  output logic [DS_W-1:0] dataset_sel,
  output logic            busy,
  output logic            done,
  output logic            timeout_err,
  output logic [15:0]     run_cnt,
  output logic [31:0]     checksum
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DS_W-1:0] DS_LAST = DS_W'(DATASET_NUM - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            enable_prev_q, enable_prev_d;
  logic [15:0]     num_runs_q, num_runs_d;
  logic [15:0]     gap_q, gap_d;
  logic [15:0]     gap_cnt_q, gap_cnt_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic [15:0]     run_cnt_q, run_cnt_d;
  logic [DS_W-1:0] dataset_q, dataset_d;
  logic [31:0]     checksum_q, checksum_d;
  logic            timeout_err_q, timeout_err_d;
  logic            k_ap_start_q, k_ap_start_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            run_done;
  logic            start_entry;
  logic [15:0]     run_inc;

  assign run_inc = run_cnt_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    enable_prev_d = enable;
    num_runs_d    = num_runs_q;
    gap_d         = gap_q;
    gap_cnt_d     = gap_cnt_q;
    wdog_d        = wdog_q;
    run_cnt_d     = run_cnt_q;
    dataset_d     = dataset_q;
    checksum_d    = checksum_q;
    timeout_err_d = timeout_err_q;
    run_done      = 1'b0;
    start_entry   = 1'b0;

    if (busy_q && out_write) begin
      checksum_d = {checksum_q[30:0], checksum_q[31]} ^ out_din;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable && !enable_prev_q) begin
          timeout_err_d = 1'b0;
          if (num_runs != 16'd0) begin
            num_runs_d  = num_runs;
            gap_d       = gap_cycles;
            run_cnt_d   = 16'd0;
            checksum_d  = 32'd0;
            dataset_d   = '0;
            state_d     = ST_START;
            start_entry = 1'b1;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_START, ST_WAIT: begin
        // A done pulse wins over a watchdog expiry in the same cycle.
        if (k_ap_done) begin
          run_done = 1'b1;
        end else if (wdog_q == WD_LAST) begin
          state_d       = ST_ERROR;
          timeout_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
          if (state_q == ST_START && k_ap_ready) begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 16'd1) begin
          state_d     = ST_START;
          start_entry = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_ERROR: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (run_done) begin
      run_cnt_d = (run_cnt_q == 16'hFFFF) ? run_cnt_q : run_inc;
      dataset_d = (dataset_q == DS_LAST) ? '0 : dataset_q + DS_W'(1);
      if (run_inc == num_runs_q || !enable) begin
        state_d = ST_FINISH;
      end else if (gap_q == 16'd0) begin
        state_d     = ST_START;
        start_entry = 1'b1;
      end else begin
        state_d   = ST_GAP;
        gap_cnt_d = gap_q;
      end
    end

    if (start_entry) begin
      wdog_d = '0;
    end

    k_ap_start_d = (state_d == ST_START);
    busy_d       = (state_d == ST_START) || (state_d == ST_WAIT) ||
                   (state_d == ST_GAP)   || (state_d == ST_ERROR);
    done_d       = (state_d == ST_FINISH);
  end

  // enable_prev resets high so a level already present at release is not a launch.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q       <= ST_IDLE;
      enable_prev_q <= 1'b1;
      num_runs_q    <= 16'd0;
      gap_q         <= 16'd0;
      gap_cnt_q     <= 16'd0;
      wdog_q        <= '0;
      run_cnt_q     <= 16'd0;
      dataset_q     <= '0;
      checksum_q    <= 32'd0;
      timeout_err_q <= 1'b0;
      k_ap_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      enable_prev_q <= enable_prev_d;
      num_runs_q    <= num_runs_d;
      gap_q         <= gap_d;
      gap_cnt_q     <= gap_cnt_d;
      wdog_q        <= wdog_d;
      run_cnt_q     <= run_cnt_d;
      dataset_q     <= dataset_d;
      checksum_q    <= checksum_d;
      timeout_err_q <= timeout_err_d;
      k_ap_start_q  <= k_ap_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign k_ap_start  = k_ap_start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign run_cnt     = run_cnt_q;
  assign checksum    = checksum_q;
  assign dataset_sel = dataset_q;

endmodule
`default_nettype wire

// File: tb/tb_kernel_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_kernel_run_ctrl
// Brief   : Randomised sweeps against a transaction-level kernel/run model.
// Revision: 1.0
// ============================================================================
module tb_kernel_run_ctrl;

  localparam int DN = 8;
  localparam int TO = 100;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        enable;
  logic [15:0] num_runs;
  logic [15:0] gap_cycles;
  logic        k_ap_start;
  logic        k_ap_ready;
  logic        k_ap_done;
  logic        out_write;
  logic [31:0] out_din;
  logic [2:0]  dataset_sel;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [15:0] run_cnt;
  logic [31:0] checksum;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  kernel_run_ctrl #(.DATASET_NUM(DN), .TIMEOUT_CYCLES(TO)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .enable(enable),
    .num_runs(num_runs), .gap_cycles(gap_cycles),
    .k_ap_start(k_ap_start), .k_ap_ready(k_ap_ready), .k_ap_done(k_ap_done),
    .out_write(out_write), .out_din(out_din), .dataset_sel(dataset_sel),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .run_cnt(run_cnt), .checksum(checksum)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] cs_next(input logic [31:0] c, input logic [31:0] w);
    return ((c << 1) | (c >> 31)) ^ w;
  endfunction

  // One sweep; the kernel answers ready rl cycles after start appears and done
  // rl+dl cycles after it. Enable drops during run index drop_run (-1 = never).
  // wmode: 0 no stream, 1 random stream, 2 words 0x1,0x2 in the first run.
  task automatic sweep(input int n, input int gap, input int rl, input int dl,
                       input int drop_run, input int wmode);
    int exp_runs, run, starts, t0, k, next_start, exp_done_at, done_cnt;
    bit in_run;
    logic [31:0] cs, w;
    exp_runs = (drop_run >= 0 && drop_run < n) ? drop_run + 1 : n;
    run = 0; starts = 0; t0 = 0; next_start = -1; exp_done_at = -1; done_cnt = 0;
    in_run = 1'b0; cs = 32'd0;
    enable = 1'b0; k_ap_ready = 1'b0; k_ap_done = 1'b0; out_write = 1'b0;
    step();
    num_runs = 16'(n); gap_cycles = 16'(gap); enable = 1'b1;
    step();
    check_val("launch_terr", timeout_err, 0);
    if (n == 0) exp_done_at = cyc;
    for (int g = 0; g < 3000; g++) begin
      if (done) begin
        done_cnt++;
        check_val("done_time", cyc, exp_done_at);
        check_val("done_busy", busy, 0);
      end
      if (done_cnt > 0 && cyc >= exp_done_at + 3) break;
      k_ap_ready = 1'b0; k_ap_done = 1'b0; out_write = 1'b0;
      if (!in_run && k_ap_start) begin
        starts++;
        check_val("ds_sel", dataset_sel, run % DN);
        check_val("run_cnt", run_cnt, run);
        if (run > 0) check_val("gap_len", cyc, next_start);
        in_run = 1'b1; t0 = cyc;
      end
      if (in_run) begin
        k = cyc - t0;
        if (k <= rl) check_val("start_held", k_ap_start, 1);
        if (k == rl + 1) check_val("start_drop", k_ap_start, 0);
        k_ap_ready = (k == rl);
        if (run == drop_run && k == rl) enable = 1'b0;
        if (wmode == 1 && $urandom_range(1, 0) == 1) begin
          w = $urandom; out_write = 1'b1; out_din = w; cs = cs_next(cs, w);
        end
        if (wmode == 2 && run == 0 && k < 2) begin
          w = 32'(k + 1); out_write = 1'b1; out_din = w; cs = cs_next(cs, w);
        end
        if (k == rl + dl) begin
          k_ap_done = 1'b1; in_run = 1'b0; run++;
          next_start = cyc + 1 + gap;
          if (run == exp_runs) exp_done_at = cyc + 1;
        end
      end else if (done_cnt > 0) begin
        out_write = 1'b1; out_din = 32'hFFFF_FFFF;
      end
      step();
    end
    check_val("done_cnt", done_cnt, 1);
    check_val("starts", starts, exp_runs);
    check_val("idle_busy", busy, 0);
    if (n > 0) begin
      check_val("final_run_cnt", run_cnt, exp_runs);
      check_val("final_ds", dataset_sel, exp_runs % DN);
      check_val("checksum", checksum, cs);
    end
    if (wmode == 2) check_val("cs_zero", checksum, 0);
    out_write = 1'b0; enable = 1'b0; k_ap_ready = 1'b0; k_ap_done = 1'b0;
    step();
  endtask

  task automatic timeout_case();
    int t0;
    enable = 1'b0; step();
    num_runs = 16'd2; gap_cycles = 16'd0; enable = 1'b1;
    step();
    check_val("to_start", k_ap_start, 1);
    t0 = cyc;
    k_ap_ready = 1'b1; step(); k_ap_ready = 1'b0;
    for (int g = 0; g < 200 && cyc < t0 + TO - 1; g++) step();
    check_val("to_early", timeout_err, 0);
    step();
    check_val("to_err", timeout_err, 1);
    check_val("to_kstart", k_ap_start, 0);
    check_val("to_busy", busy, 1);
    repeat (3) step();
    check_val("to_hold_busy", busy, 1);
    check_val("to_run_cnt", run_cnt, 0);
    enable = 1'b0; step();
    check_val("to_exit_busy", busy, 0);
    check_val("to_sticky", timeout_err, 1);
  endtask

  task automatic reset_mid();
    int seen;
    enable = 1'b0; step();
    num_runs = 16'd5; gap_cycles = 16'd2; enable = 1'b1;
    step();
    check_val("rm_start1", k_ap_start, 1);
    k_ap_ready = 1'b1; k_ap_done = 1'b1; out_write = 1'b1; out_din = 32'hA5;
    step();
    k_ap_ready = 1'b0; k_ap_done = 1'b0; out_write = 1'b0;
    for (int g = 0; g < 20 && !k_ap_start; g++) step();
    check_val("rm_start2", k_ap_start, 1);
    k_ap_ready = 1'b1; step(); k_ap_ready = 1'b0; step();
    check_val("rm_pre_busy", busy, 1);
    check_val("rm_pre_cs", checksum, 32'hA5);
    check_val("rm_pre_ds", dataset_sel, 1);
    #2 ap_rst = 1'b1;
    #1;
    check_val("rm_kstart", k_ap_start, 0);
    check_val("rm_busy", busy, 0);
    check_val("rm_done", done, 0);
    check_val("rm_run_cnt", run_cnt, 0);
    check_val("rm_cs", checksum, 0);
    check_val("rm_ds", dataset_sel, 0);
    check_val("rm_terr", timeout_err, 0);
    repeat (2) step();
    ap_rst = 1'b0;
    seen = 0;
    for (int g = 0; g < 20; g++) begin
      step();
      if (k_ap_start || done || busy) seen++;
    end
    check_val("rm_no_relaunch", seen, 0);
    enable = 1'b0; step();
  endtask

  initial begin
    ap_rst = 1'b1; enable = 1'b0; num_runs = 16'd0; gap_cycles = 16'd0;
    k_ap_ready = 1'b0; k_ap_done = 1'b0; out_write = 1'b0; out_din = 32'd0;
    repeat (2) step();
    check_val("rst_kstart", k_ap_start, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_terr", timeout_err, 0);
    check_val("rst_run_cnt", run_cnt, 0);
    check_val("rst_cs", checksum, 0);
    check_val("rst_ds", dataset_sel, 0);
    ap_rst = 1'b0;
    step();

    sweep(3, 4, 1, 10, -1, 1);
    sweep(10, 1, 1, 2, -1, 1);
    sweep(3, 0, 0, 0, -1, 0);
    sweep(1, 0, 0, 3, -1, 2);
    sweep(0, 2, 1, 1, -1, 0);
    sweep(4, 2, 1, 5, 1, 1);
    timeout_case();
    sweep(2, 1, 1, 2, -1, 1);
    reset_mid();
    for (int i = 0; i < 15; i++) begin
      int n;
      n = $urandom_range(12, 1);
      sweep(n, $urandom_range(5, 0), $urandom_range(3, 0), $urandom_range(6, 0),
            ($urandom_range(3, 0) == 0) ? $urandom_range(n - 1, 0) : -1, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
